// File: rtl/count_display_pkg.sv
// -----------------------------------------------------------------------------
// count_display_pkg
// Shared definitions for the count display driver:
//   - scan_state_t : display scan FSM states
//   - SEG_0..SEG_9 : 7-segment patterns, bit order {g,f,e,d,c,b,a}, active-high
//   - SEG_BLANK    : all segments off (active-high)
//   - EN_*         : digit enable codes, [0]=ones digit, [1]=tens digit
// -----------------------------------------------------------------------------
package count_display_pkg;

    typedef enum logic [1:0] {
        BLANK_A = 2'd0,
        ONES    = 2'd1,
        BLANK_B = 2'd2,
        TENS    = 2'd3
    } scan_state_t;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    localparam logic [1:0] EN_OFF  = 2'b00;
    localparam logic [1:0] EN_ONES = 2'b01;
    localparam logic [1:0] EN_TENS = 2'b10;

endpackage

// File: rtl/count_display_driver_if.sv
// -----------------------------------------------------------------------------
// count_display_driver_if
// Groups the count input side and the display output side of the driver.
//   count_in [3:0] : count value to display (0-15)
//   sample         : capture count_in into the hold register at the clock edge
//   seg      [6:0] : segment drive {g,f,e,d,c,b,a}
//   digit_en [1:0] : [0]=ones digit, [1]=tens digit
// Modports:
//   master : count source / display observer (drives count_in, sample)
//   slave  : the display driver (drives seg, digit_en)
// -----------------------------------------------------------------------------
interface count_display_driver_if;

    logic [3:0] count_in;
    logic       sample;
    logic [6:0] seg;
    logic [1:0] digit_en;

    modport master (
        output count_in,
        output sample,
        input  seg,
        input  digit_en
    );

    modport slave (
        input  count_in,
        input  sample,
        output seg,
        output digit_en
    );

endinterface

// File: rtl/seg7_decode.sv
// -----------------------------------------------------------------------------
// seg7_decode
// Combinational decimal digit to 7-segment pattern decoder.
//   digit [3:0] : digit value; 0-9 decode to their pattern, 10-15 to SEG_BLANK
//   seg   [6:0] : pattern {g,f,e,d,c,b,a}, active-high
// -----------------------------------------------------------------------------
module seg7_decode
    import count_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        // NOTE: default assigned first so every path drives seg; no latch is inferred.
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/count_display_driver.sv
// -----------------------------------------------------------------------------
// count_display_driver
// Captures a 0-15 count on request, splits it into tens/ones decimal digits and
// scans a 2-digit multiplexed 7-segment display:
//   BLANK_A (1) -> ONES (SCAN_DIV) -> BLANK_B (1) -> TENS (SCAN_DIV) -> ...
// The blank cycles between digits suppress ghosting. All outputs are registered
// and the displayed digit is latched when its phase is entered.
//
// Parameters:
//   SCAN_DIV       : cycles each digit is lit (1-255)
//   SEG_ACTIVE_LOW : 1 inverts seg and digit_en, including inactive levels
// Ports:
//   clock : system clock, rising edge
//   clear : synchronous active-high reset
//   bus   : count_display_driver_if.slave (count_in, sample, seg, digit_en)
// Build option:
//   LEADING_ZERO_BLANK_EN : when defined, a tens digit of 0 is not lit; the
//                           TENS phase keeps its timing but stays inactive.
// -----------------------------------------------------------------------------
module count_display_driver
    import count_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 4,
    parameter bit          SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                   clock,
    input  logic                   clear,
    count_display_driver_if.slave  bus
);

    localparam logic [7:0] PHASE_LAST = 8'(SCAN_DIV - 1);
    // XOR masks applied just before the output registers
    localparam logic [6:0] SEG_POL    = {7{SEG_ACTIVE_LOW}};
    localparam logic [1:0] EN_POL     = {2{SEG_ACTIVE_LOW}};

    logic [3:0]  hold;
    scan_state_t state;
    scan_state_t next_state;
    logic [7:0]  phase_cnt;
    logic        phase_done;
    logic        state_change;

    logic        tens_bit;
    logic [3:0]  ones_digit;
    logic [3:0]  tens_digit;
    logic [3:0]  digit_sel;
    logic [6:0]  pattern;

    logic [6:0]  seg_q;
    logic [1:0]  en_q;
    logic [6:0]  seg_next;
    logic [1:0]  en_next;

    // Digit split: hold is at most 15, so tens is 0 or 1 and ones = hold - 10*tens
    assign tens_bit   = (hold >= 4'd10);
    assign ones_digit = tens_bit ? (hold - 4'd10) : hold;
    assign tens_digit = {3'b000, tens_bit};

    // Decode the digit of the phase about to be entered
    assign digit_sel  = (next_state == TENS) ? tens_digit : ones_digit;

    seg7_decode u_decode (
        .digit (digit_sel),
        .seg   (pattern)
    );

    // Next-state logic
    always_comb begin
        next_state = state;
        phase_done = (phase_cnt == PHASE_LAST);
        case (state)
            BLANK_A: next_state = ONES;
            ONES:    if (phase_done) next_state = BLANK_B;
            BLANK_B: next_state = TENS;
            TENS:    if (phase_done) next_state = BLANK_A;
            default: next_state = BLANK_A;
        endcase
        state_change = (next_state != state);
    end

    // Output values are loaded only on phase entry and held for the whole phase
    always_comb begin
        seg_next = seg_q;
        en_next  = en_q;
        if (state_change) begin
            case (next_state)
                ONES: begin
                    seg_next = SEG_POL ^ pattern;
                    en_next  = EN_POL ^ EN_ONES;
                end
                TENS: begin
`ifdef LEADING_ZERO_BLANK_EN
                    if (tens_bit) begin
                        seg_next = SEG_POL ^ pattern;
                        en_next  = EN_POL ^ EN_TENS;
                    end else begin
                        seg_next = SEG_POL ^ SEG_BLANK;
                        en_next  = EN_POL ^ EN_OFF;
                    end
`else
                    seg_next = SEG_POL ^ pattern;
                    en_next  = EN_POL ^ EN_TENS;
`endif
                end
                default: begin
                    seg_next = SEG_POL ^ SEG_BLANK;
                    en_next  = EN_POL ^ EN_OFF;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (clear) begin
            hold      <= 4'd0;
            state     <= BLANK_A;
            phase_cnt <= 8'd0;
            seg_q     <= SEG_POL ^ SEG_BLANK;
            en_q      <= EN_POL ^ EN_OFF;
        end else begin
            if (bus.sample) begin
                hold <= bus.count_in;
            end
            state     <= next_state;
            phase_cnt <= state_change ? 8'd0 : (phase_cnt + 8'd1);
            seg_q     <= seg_next;
            en_q      <= en_next;
        end
    end

    assign bus.seg      = seg_q;
    assign bus.digit_en = en_q;

endmodule

// File: doc/count_display_driver.md
Name: count_display_driver

Overview:
- Downstream consumer of the 4-bit modulo-16 count: samples a 0–15 count value on request.
- Splits the held value into tens/ones decimal digits and drives a 2-digit, time-multiplexed 7-segment display.
- A scan FSM inserts one blank cycle between digits to prevent ghosting; all outputs are registered.

Parameters:
- SCAN_DIV, 4, clock cycles each digit is lit; legal range 1–255.
- SEG_ACTIVE_LOW, 0, 1 inverts seg and digit_en polarity at the output register.

Ports:
- clock  input  1  system clock, rising edge.
- clear  input  1  synchronous active-high reset.
- count_in  input  4  count value to display (0–15).
- sample  input  1  when high at a clock edge, count_in is captured into the hold register.
- seg  output  7  segment drive {g,f,e,d,c,b,a}.
- digit_en  output  2  [0]=ones digit, [1]=tens digit.

Behaviour:
- Clock and reset: one clock (clock); reset is clear, synchronous and active-high; all state updates on the rising edge of clock.
- Clear (any edge with clear=1):
  - hold register = 0; state = BLANK_A; phase counter = 0.
  - seg = all-inactive; digit_en = all-inactive.
  - Clear wins over a simultaneous sample; clear mid-phase aborts the phase immediately.
- Sample: the hold register loads count_in at each edge with sample=1 and clear=0. Otherwise it holds.
- Digit split: tens = (hold >= 10) ? 1 : 0; ones = hold − 10*tens. Only 5 bits of arithmetic are needed.
- FSM states: BLANK_A, ONES, BLANK_B, TENS.
  - BLANK_A -> ONES after 1 cycle.
  - ONES -> BLANK_B after SCAN_DIV cycles.
  - BLANK_B -> TENS after 1 cycle.
  - TENS -> BLANK_A after SCAN_DIV cycles.
  - Full scan period = 2*SCAN_DIV + 2 cycles.
  - The phase counter resets on every state entry.
- Registered outputs:
  - On the edge entering ONES: digit_en = 01 and seg = pattern(ones).
  - On the edge entering TENS: digit_en = 10 and seg = pattern(tens).
  - On the edge entering a BLANK state: seg and digit_en go all-inactive.
- Phase latching: the digit value is captured on phase entry. A sample during a lit phase does not alter that phase; the new value appears at the next entry of each digit.
- Segment patterns, gfedcba, active-high:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110
  - 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111
- Polarity: SEG_ACTIVE_LOW=1 inverts seg and digit_en, including the inactive (blank/reset) levels.
- Wrap-around: a hold value stepping 15->0 needs no special handling; it displays "15" then "00".
- count_in is never used combinationally at the outputs.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when tens=0, the TENS phase keeps seg and digit_en inactive for its full SCAN_DIV cycles. Timing is unchanged.
- Undefined: tens=0 displays pattern 0 (0111111) with digit_en=10.

Decomposition:
- Shared package count_display_pkg holds:
  - the state enum {BLANK_A, ONES, BLANK_B, TENS};
  - the ten segment-pattern constants;
  - the SEG_BLANK constant.
- One sub-module, seg7_decode: combinational 4-bit digit -> 7-bit gfedcba pattern. Inputs outside 0–9 decode to SEG_BLANK.
- The top level holds the hold register, digit split, FSM, phase counter and output registers.

Test Plan:
1. Clear 2 cycles, sample count_in=7 -> ONES phase seg=0000111, digit_en=01. TENS phase seg=0111111, digit_en=10 (macro off) or inactive for 4 cycles (macro on).
2. Sample count_in=13 -> ONES seg=1001111; TENS seg=0000110.
3. SCAN_DIV=4, free run after clear -> period 10 cycles: 1 blank, 4 ones, 1 blank, 4 tens. digit_en is never 11, and is exactly 00 in blank cycles.
4. Sample 9 at cycle 2 of a ONES phase showing 5 -> remaining ONES cycles still 1101101; next ONES phase 1101111.
5. clear=1 and sample=1 with count_in=15 on the same edge -> hold=0, outputs inactive next cycle, first ONES after release shows 0111111.
6. SEG_ACTIVE_LOW=1, value 8 -> ONES seg=0000000, digit_en=10; blank cycles seg=1111111, digit_en=11.
